disp_sched: RTL and testbench
=============================

Name: disp_sched

Overview:
- Scheduler for the shared 3-digit BCD seven-segment display.
- Arbitrates between three sources: score (background), countdown timer, and one-shot flash events (e.g. hit value).
- Score and timer rotate on a ms-based period; a flash preempts both for a fixed time.
- Outputs a registered BCD word plus blank/source flags that feed the digit-display driver directly.

Parameters:
- TICK_CYCLES, 50000, clk cycles per 1 ms tick (50 MHz clock); range 2..65535.
- ROT_MS, 2000, ms each of score/timer is shown when both are valid; range 1..4095.
- FLASH_MS, 500, ms a flash value is shown; range 1..4095.

Ports:
- clk  in  1  50 MHz system clock
- reset  in  1  asynchronous, active-low global reset
- score_vld  in  1  score source wants display (level)
- score_bcd  in  12  score digits, [11:8] hundreds, [7:4] tens, [3:0] units
- timer_vld  in  1  timer source wants display (level)
- timer_bcd  in  12  timer digits, same layout
- flash_req  in  1  single-cycle flash request
- flash_bcd  in  12  flash digits, sampled when flash_req=1
- disp_bcd  out  12  BCD word to the display driver
- disp_blank  out  1  1 = display must be blanked
- disp_src  out  2  0 none, 1 score, 2 timer, 3 flash
- flash_busy  out  1  high while in FLASH
- bcd_err  out  1  sticky: an illegal nibble was presented

Behaviour:
- Reset (async, reset=0): state IDLE, all counters 0, disp_bcd=0, disp_blank=1, disp_src=0, flash_busy=0, bcd_err=0. Reset mid-flash abandons the flash; no pending memory is kept.
- Tick prescaler:
  - 16-bit free-running counter 0..TICK_CYCLES-1; ms_tick pulses one cycle when the counter equals TICK_CYCLES-1, then wraps to 0.
  - Not restarted on state change.
- ms_cnt (12-bit):
  - Cleared on every state entry, including FLASH re-trigger.
  - Increments on ms_tick.
  - A period of N ms expires when ms_tick=1 and ms_cnt==N-1.
- States: IDLE, SHOW_SCORE, SHOW_TIMER, FLASH. Priority in every state: flash_req > valid-drop > rotation expiry.
- IDLE: flash_req -> FLASH; else score_vld -> SHOW_SCORE; else timer_vld -> SHOW_TIMER.
- SHOW_SCORE:
  - flash_req -> FLASH, with ret=SCORE.
  - Else !score_vld -> SHOW_TIMER if timer_vld, otherwise IDLE.
  - Else ROT_MS expiry with timer_vld=1 -> SHOW_TIMER.
  - Expiry with timer_vld=0 stays in SHOW_SCORE and restarts ms_cnt.
- SHOW_TIMER: mirror of SHOW_SCORE with ret=TIMER.
- FLASH:
  - Entry latches flash_bcd; ret is kept from the originating state (IDLE -> ret=NONE).
  - flash_req while in FLASH re-latches flash_bcd and clears ms_cnt (restart, no queueing).
  - On FLASH_MS expiry: go to the ret state if its vld=1; else the other source if valid; else IDLE.
- Outputs:
  - Registered and updated on the same edge as the state register, decoded from next state and the current inputs.
  - Latency: input at edge k is visible after edge k (1 cycle).
  - SHOW states track live score_bcd/timer_bcd every cycle; FLASH shows the latched value.
  - IDLE: disp_blank=1, disp_src=0, disp_bcd holds its last value.
  - flash_busy = (next state == FLASH).
- BCD check: any selected nibble >9 is forced to 0 in disp_bcd and sets bcd_err. bcd_err clears only on reset.

Decomposition:
- Shared package disp_pkg holds:
  - state encoding (IDLE=0, SHOW_SCORE=1, SHOW_TIMER=2, FLASH=3);
  - disp_src codes (SRC_NONE, SRC_SCORE, SRC_TIMER, SRC_FLASH);
  - the 1 ms TICK_CYCLES constant (shared with the digit driver's scan timing).
- One natural sub-module: ms_tick_gen (parameterised prescaler, output ms_tick), reusable by the game timer.

Test Plan:
All scenarios use TICK_CYCLES=4, ROT_MS=3, FLASH_MS=2.
- Reset: hold reset=0 with random inputs -> disp_blank=1, disp_src=0, disp_bcd=12'h000, bcd_err=0. Release with score_vld=1, score_bcd=12'h123 -> next edge disp_src=1, disp_bcd=12'h123.
- Rotation: score_vld=timer_vld=1, score=12'h045, timer=12'h030 -> disp_src alternates 1/2, switching exactly at every 3rd ms_tick (12 clk). Changing timer_bcd to 12'h029 mid-slot shows it the next cycle.
- Flash preempt and return:
  - In SHOW_TIMER, flash_req with 12'h999 -> next edge disp_src=3, flash_busy=1, disp_bcd=12'h999.
  - After 2 ms ticks -> disp_src=2.
  - With timer_vld dropped during the flash -> disp_src=1 instead.
- Flash re-trigger: second flash_req (12'h777) one tick into a flash -> disp_bcd=12'h777, total FLASH dwell = 1 + 2 ticks. Reset asserted mid-flash -> IDLE, flash_busy=0.
- Simultaneous events: flash_req in the same cycle as score_vld falls and rotation expires -> FLASH wins. Valid drop on the expiry cycle -> drop path taken. Both vld low -> disp_blank=1.
- Illegal BCD: score_bcd=12'h1A3 -> disp_bcd=12'h103, bcd_err=1, remaining 1 after the input returns legal; cleared only by reset.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the score/timer/flash display scheduler.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHOW_SCORE = 2'd1,
    SHOW_TIMER = 2'd2,
    FLASH      = 2'd3
  } state_t;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_SCORE = 2'd1;
  localparam logic [1:0] SRC_TIMER = 2'd2;
  localparam logic [1:0] SRC_FLASH = 2'd3;

  localparam int TICK_CYCLES = 50000;

  function automatic logic [11:0] bcd_fix(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    for (int i = 0; i < 3; i++) begin
      if (v[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd0;
    end
    return r;
  endfunction

  function automatic logic bcd_bad(input logic [11:0] v);
    logic b;
    b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (v[i*4 +: 4] > 4'd9) b = 1'b1;
    end
    return b;
  endfunction

endpackage

// File: rtl/disp_sched_ms_tick_gen.sv
// Free-running 1 ms prescaler: ms_tick pulses on the last count.
module ms_tick_gen #(
  parameter int TICK_CYCLES = disp_pkg::TICK_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  output logic ms_tick
);
  localparam logic [15:0] LAST = 16'(TICK_CYCLES - 1);

  logic [15:0] cnt;

  assign ms_tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (ms_tick) cnt <= '0;
    else cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/disp_sched.sv
// Arbitrates score, timer and flash sources onto the 3-digit BCD display.
module disp_sched #(
  parameter int TICK_CYCLES = disp_pkg::TICK_CYCLES,
  parameter int ROT_MS      = 2000,
  parameter int FLASH_MS    = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        score_vld,
  input  logic [11:0] score_bcd,
  input  logic        timer_vld,
  input  logic [11:0] timer_bcd,
  input  logic        flash_req,
  input  logic [11:0] flash_bcd,
  output logic [11:0] disp_bcd,
  output logic        disp_blank,
  output logic [1:0]  disp_src,
  output logic        flash_busy,
  output logic        bcd_err
);
  import disp_pkg::*;

  localparam logic [11:0] ROT_LAST   = 12'(ROT_MS - 1);
  localparam logic [11:0] FLASH_LAST = 12'(FLASH_MS - 1);

  state_t      state, state_n;
  logic [1:0]  ret, ret_n;
  logic [11:0] ms_cnt, ms_cnt_n;
  logic [11:0] flash_lat, flash_n;
  logic [11:0] sel, bcd_n;
  logic [1:0]  src_n;
  logic        blank_n, busy_n, err_n;
  logic        ms_tick, rot_exp, fl_exp, clr;

  ms_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk    (clk),
    .rst_n  (reset),
    .ms_tick(ms_tick)
  );

  assign rot_exp = ms_tick && (ms_cnt == ROT_LAST);
  assign fl_exp  = ms_tick && (ms_cnt == FLASH_LAST);
  assign flash_n = flash_req ? flash_bcd : flash_lat;

  always_comb begin
    state_n = state;
    ret_n   = ret;
    clr     = 1'b0;
    unique case (state)
      IDLE: begin
        if (flash_req) begin
          state_n = FLASH;
          ret_n   = SRC_NONE;
        end else if (score_vld) state_n = SHOW_SCORE;
        else if (timer_vld) state_n = SHOW_TIMER;
      end
      SHOW_SCORE: begin
        if (flash_req) begin
          state_n = FLASH;
          ret_n   = SRC_SCORE;
        end else if (!score_vld) begin
          state_n = timer_vld ? SHOW_TIMER : IDLE;
        end else if (rot_exp) begin
          if (timer_vld) state_n = SHOW_TIMER;
          else clr = 1'b1;
        end
      end
      SHOW_TIMER: begin
        if (flash_req) begin
          state_n = FLASH;
          ret_n   = SRC_TIMER;
        end else if (!timer_vld) begin
          state_n = score_vld ? SHOW_SCORE : IDLE;
        end else if (rot_exp) begin
          if (score_vld) state_n = SHOW_SCORE;
          else clr = 1'b1;
        end
      end
      FLASH: begin
        if (flash_req) clr = 1'b1;
        else if (fl_exp) begin
          // return source first, then whichever other source is live
          if (ret == SRC_SCORE && score_vld) state_n = SHOW_SCORE;
          else if (ret == SRC_TIMER && timer_vld) state_n = SHOW_TIMER;
          else if (score_vld) state_n = SHOW_SCORE;
          else if (timer_vld) state_n = SHOW_TIMER;
          else state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ms_cnt_n = ms_cnt;
    if (clr || (state_n != state)) ms_cnt_n = '0;
    else if (ms_tick) ms_cnt_n = ms_cnt + 12'd1;
  end

  always_comb begin
    sel     = '0;
    blank_n = 1'b0;
    src_n   = SRC_NONE;
    unique case (state_n)
      SHOW_SCORE: begin
        sel   = score_bcd;
        src_n = SRC_SCORE;
      end
      SHOW_TIMER: begin
        sel   = timer_bcd;
        src_n = SRC_TIMER;
      end
      FLASH: begin
        sel   = flash_n;
        src_n = SRC_FLASH;
      end
      default: blank_n = 1'b1;
    endcase
    bcd_n  = (state_n == IDLE) ? disp_bcd : bcd_fix(sel);
    err_n  = bcd_err | ((state_n != IDLE) && bcd_bad(sel));
    busy_n = (state_n == FLASH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ret        <= SRC_NONE;
      ms_cnt     <= '0;
      flash_lat  <= '0;
      disp_bcd   <= '0;
      disp_blank <= 1'b1;
      disp_src   <= SRC_NONE;
      flash_busy <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      state      <= state_n;
      ret        <= ret_n;
      ms_cnt     <= ms_cnt_n;
      flash_lat  <= flash_n;
      disp_bcd   <= bcd_n;
      disp_blank <= blank_n;
      disp_src   <= src_n;
      flash_busy <= busy_n;
      bcd_err    <= err_n;
    end
  end

endmodule

// File: tb/tb_disp_sched.sv
// Scoreboard bench for disp_sched with TICK_CYCLES=4, ROT_MS=3, FLASH_MS=2.
module tb_disp_sched;

  logic        clk;
  logic        reset;
  logic        score_vld;
  logic [11:0] score_bcd;
  logic        timer_vld;
  logic [11:0] timer_bcd;
  logic        flash_req;
  logic [11:0] flash_bcd;
  logic [11:0] disp_bcd;
  logic        disp_blank;
  logic [1:0]  disp_src;
  logic        flash_busy;
  logic        bcd_err;

  disp_sched #(.TICK_CYCLES(4), .ROT_MS(3), .FLASH_MS(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .score_vld (score_vld),
    .score_bcd (score_bcd),
    .timer_vld (timer_vld),
    .timer_bcd (timer_bcd),
    .flash_req (flash_req),
    .flash_bcd (flash_bcd),
    .disp_bcd  (disp_bcd),
    .disp_blank(disp_blank),
    .disp_src  (disp_src),
    .flash_busy(flash_busy),
    .bcd_err   (bcd_err)
  );

  typedef struct {
    int          e;
    string       name;
    logic [16:0] v;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   base = 0;
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // monitor: compare every expectation due at the edge just taken
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].e <= edge_cnt) begin
      exp_t x;
      logic [16:0] act;
      x = q.pop_front();
      act = {disp_bcd, disp_blank, disp_src, flash_busy, bcd_err};
      checks++;
      if (x.e != edge_cnt || act !== x.v) begin
        errors++;
        $display("FAIL %s edge=%0d bcd/blank/src/busy/err got=%h/%b/%0d/%b/%b want=%h/%b/%0d/%b/%b",
                 x.name, edge_cnt - base,
                 act[16:5], act[4], act[3:2], act[1], act[0],
                 x.v[16:5], x.v[4], x.v[3:2], x.v[1], x.v[0]);
      end
    end
  end

  task automatic chk(input string nm, input logic [11:0] b,
                     input logic bl, input logic [1:0] s,
                     input logic bz, input logic er);
    exp_t x;
    x.e = edge_cnt + 1;
    x.name = nm;
    x.v = {b, bl, s, bz, er};
    q.push_back(x);
    @(negedge clk);
  endtask

  task automatic run_to(input int j);
    while (edge_cnt - base < j) @(negedge clk);
  endtask

  initial begin
    reset     = 1'b0;
    score_vld = 1'($urandom);
    score_bcd = 12'($urandom);
    timer_vld = 1'($urandom);
    timer_bcd = 12'($urandom);
    flash_req = 1'($urandom);
    flash_bcd = 12'($urandom);
    @(negedge clk);
    chk("rst_hold0", 12'h000, 1'b1, 2'd0, 1'b0, 1'b0);
    flash_req = 1'b1;
    score_bcd = 12'hFFF;
    chk("rst_hold1", 12'h000, 1'b1, 2'd0, 1'b0, 1'b0);

    reset     = 1'b1;
    score_vld = 1'b1;
    score_bcd = 12'h123;
    timer_vld = 1'b0;
    flash_req = 1'b0;
    base      = edge_cnt;
    chk("release", 12'h123, 1'b0, 2'd1, 1'b0, 1'b0);

    score_bcd = 12'h045;
    timer_bcd = 12'h030;
    timer_vld = 1'b1;
    for (int j = 2; j <= 36; j++) begin
      if (j == 17) timer_bcd = 12'h029;
      if (j < 12 || (j >= 24 && j < 36))
        chk("rot_score", 12'h045, 1'b0, 2'd1, 1'b0, 1'b0);
      else
        chk("rot_timer", (j >= 17) ? 12'h029 : 12'h030,
            1'b0, 2'd2, 1'b0, 1'b0);
    end

    flash_req = 1'b1;
    flash_bcd = 12'h999;
    chk("flash_enter", 12'h999, 1'b0, 2'd3, 1'b1, 1'b0);
    flash_req = 1'b0;
    flash_bcd = 12'h000;
    for (int j = 38; j <= 43; j++)
      chk("flash_hold", 12'h999, 1'b0, 2'd3, 1'b1, 1'b0);
    chk("flash_ret_timer", 12'h029, 1'b0, 2'd2, 1'b0, 1'b0);

    flash_req = 1'b1;
    flash_bcd = 12'h888;
    chk("flash2_enter", 12'h888, 1'b0, 2'd3, 1'b1, 1'b0);
    flash_req = 1'b0;
    chk("flash2_hold", 12'h888, 1'b0, 2'd3, 1'b1, 1'b0);
    timer_vld = 1'b0;
    for (int j = 47; j <= 51; j++)
      chk("flash2_hold", 12'h888, 1'b0, 2'd3, 1'b1, 1'b0);
    chk("flash_ret_other", 12'h045, 1'b0, 2'd1, 1'b0, 1'b0);

    flash_req = 1'b1;
    flash_bcd = 12'h555;
    chk("flash3_enter", 12'h555, 1'b0, 2'd3, 1'b1, 1'b0);
    flash_req = 1'b0;
    for (int j = 54; j <= 56; j++)
      chk("flash3_hold", 12'h555, 1'b0, 2'd3, 1'b1, 1'b0);
    flash_req = 1'b1;
    flash_bcd = 12'h777;
    chk("retrig", 12'h777, 1'b0, 2'd3, 1'b1, 1'b0);
    flash_req = 1'b0;
    for (int j = 58; j <= 63; j++)
      chk("retrig_hold", 12'h777, 1'b0, 2'd3, 1'b1, 1'b0);
    chk("retrig_end", 12'h045, 1'b0, 2'd1, 1'b0, 1'b0);

    timer_vld = 1'b1;
    for (int j = 65; j <= 75; j++)
      chk("score_slot", 12'h045, 1'b0, 2'd1, 1'b0, 1'b0);
    flash_req = 1'b1;
    flash_bcd = 12'h246;
    score_vld = 1'b0;
    chk("simul_flash_wins", 12'h246, 1'b0, 2'd3, 1'b1, 1'b0);
    flash_req = 1'b0;
    run_to(83);
    chk("simul_ret_timer", 12'h029, 1'b0, 2'd2, 1'b0, 1'b0);

    run_to(95);
    timer_vld = 1'b0;
    chk("drop_to_idle", 12'h029, 1'b1, 2'd0, 1'b0, 1'b0);

    score_vld = 1'b1;
    score_bcd = 12'h1A3;
    chk("bad_bcd", 12'h103, 1'b0, 2'd1, 1'b0, 1'b1);
    score_bcd = 12'h045;
    chk("err_sticky", 12'h045, 1'b0, 2'd1, 1'b0, 1'b1);
    flash_req = 1'b1;
    flash_bcd = 12'h321;
    chk("flash4_enter", 12'h321, 1'b0, 2'd3, 1'b1, 1'b1);
    flash_req = 1'b0;
    reset     = 1'b0;
    chk("rst_midflash", 12'h000, 1'b1, 2'd0, 1'b0, 1'b0);
    score_vld = 1'b0;
    timer_vld = 1'b0;
    chk("rst_midflash2", 12'h000, 1'b1, 2'd0, 1'b0, 1'b0);
    reset = 1'b1;
    base  = edge_cnt;
    chk("post_rst_idle", 12'h000, 1'b1, 2'd0, 1'b0, 1'b0);
    chk("post_rst_idle2", 12'h000, 1'b1, 2'd0, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
